// File: rtl/fetch_decode_register.sv
// IF/ID pipeline register with a one-entry skid buffer, hazard stall, branch flush
// and a saturating bubble counter for performance monitoring.
module fetch_decode_register #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              CNT_W    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  bubble_count
);

  // Handshake: a word moves from fetch when in_valid & in_ready on a rising edge.
  // in_ready is a flop output (!skid_valid_q), so it never depends on stall/flush.

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]   main_pc_q,    main_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic [CNT_W-1:0]  bubble_q,     bubble_d;

  logic handshake;
  logic advance;

  assign in_ready  = !skid_valid_q;
  assign handshake = in_valid & in_ready;
  assign advance   = !main_valid_q | !stall;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_instr_d = NOP_WORD;
      skid_valid_d = 1'b0;
    end else if (advance) begin
      // The skid entry is older than anything fetch offers, so it drains first.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (handshake) begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end else begin
        main_valid_d = 1'b0;
        main_instr_d = NOP_WORD;
      end
    end else if (handshake) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if ((!main_valid_q || stall) && !(&bubble_q)) begin
      bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_WORD;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      bubble_q     <= bubble_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_instr    = main_instr_q;
  assign out_pc       = main_pc_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_fetch_decode_register.sv
// Bench for fetch_decode_register: a queue-based reference model checked every cycle,
// plus directed literal checks; a narrow-counter instance exercises saturation.
module tb_fetch_decode_register;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [15:0] bubble_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_instr, s_out_pc;
  logic [2:0]  s_bubble_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  fetch_decode_register dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .bubble_count(bubble_count)
  );

  fetch_decode_register #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .stall(stall), .flush(flush),
    .out_valid(s_out_valid), .out_instr(s_out_instr), .out_pc(s_out_pc),
    .bubble_count(s_bubble_count)
  );

  // Reference model: instructions in flight, oldest (the one on the output) at index 0.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_last_pc = '0;
  int unsigned m_bub = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last_pc = '0;
      m_bub     = 0;
    end else begin
      bit hs;
      ent_t e;
      hs = in_valid && (mq.size() < 2);
      e.instr = in_instr;
      e.pc    = in_pc;
      if (mq.size() == 0 || stall) m_bub++;
      if (flush) begin
        mq.delete();
      end else if (mq.size() == 0 || !stall) begin
        if (mq.size() > 0) void'(mq.pop_front());
        if (hs) mq.push_back(e);
      end else if (hs) begin
        mq.push_back(e);
      end
      if (mq.size() > 0) m_last_pc = mq[0].pc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic        e_valid;
      logic [31:0] e_instr, e_pc;
      int unsigned e_bub, e_sbub;
      e_valid = (mq.size() > 0);
      e_instr = e_valid ? mq[0].instr : 32'h0;
      e_pc    = e_valid ? mq[0].pc : m_last_pc;
      e_bub   = (m_bub > 65535) ? 65535 : m_bub;
      e_sbub  = (m_bub > 7) ? 7 : m_bub;
      check("m_out_valid", 64'(out_valid), 64'(e_valid));
      check("m_out_instr", 64'(out_instr), 64'(e_instr));
      check("m_out_pc",    64'(out_pc),    64'(e_pc));
      check("m_in_ready",  64'(in_ready),  64'(mq.size() < 2));
      check("m_bubble",    64'(bubble_count), 64'(e_bub));
      check("s_out_valid", 64'(s_out_valid), 64'(e_valid));
      check("s_out_instr", 64'(s_out_instr), 64'(e_instr));
      check("s_out_pc",    64'(s_out_pc),    64'(e_pc));
      check("s_in_ready",  64'(s_in_ready),  64'(mq.size() < 2));
      check("s_bubble",    64'(s_bubble_count), 64'(e_sbub));
    end
  end

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic st, input logic fl);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    stall    = st;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h1);
    check("rst_out_instr", 64'(out_instr), 64'h0);
    check("rst_out_pc",    64'(out_pc),    64'h0);
    check("rst_bubble",    64'(bubble_count), 64'h0);

    // Streaming, no stall: one word per cycle, one-cycle latency.
    drive(1'b1, 32'h1000_0001, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        check("s1_valid", 64'(out_valid), 64'h1);
        check("s1_instr", 64'(out_instr), 64'h1000_0001);
        check("s1_bubble", 64'(bubble_count), 64'h1);
      end
      if (k < 5) drive(1'b1, 32'h1000_0001 + 32'(k), 32'(4 * k), 1'b0, 1'b0);
    end
    check("s5_instr",  64'(out_instr), 64'h1000_0005);
    check("s5_pc",     64'(out_pc),    64'h10);
    check("s5_ready",  64'(in_ready),  64'h1);
    check("s5_bubble", 64'(bubble_count), 64'h1);

    // Stall 3 cycles holding A while B is captured in the skid.
    drive(1'b1, 32'hA, 32'h100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 32'h104, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    check("st_instr",  64'(out_instr), 64'hA);
    check("st_ready",  64'(in_ready),  64'h0);
    check("st_bubble", 64'(bubble_count), 64'h4);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("drain_instr", 64'(out_instr), 64'hB);
    check("drain_pc",    64'(out_pc),    64'h104);
    check("drain_ready", 64'(in_ready),  64'h1);

    // Flush with C in main, D in skid and E offered.
    drive(1'b1, 32'hC, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hD, 32'h204, 1'b1, 1'b0);
    tick();
    check("skid_full", 64'(in_ready), 64'h0);
    drive(1'b1, 32'hE, 32'h208, 1'b0, 1'b1);
    tick();
    check("fl_valid", 64'(out_valid), 64'h0);
    check("fl_instr", 64'(out_instr), 64'h0);
    check("fl_ready", 64'(in_ready),  64'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    // Flush and stall together: flush wins.
    drive(1'b1, 32'hF, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    check("fs_valid", 64'(out_valid), 64'h0);
    check("fs_instr", 64'(out_instr), 64'h0);

    // Asynchronous reset mid-cycle while the skid is full.
    drive(1'b1, 32'h11, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h12, 32'h404, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",  64'(out_valid), 64'h0);
    check("ar_ready",  64'(in_ready),  64'h1);
    check("ar_instr",  64'(out_instr), 64'h0);
    check("ar_pc",     64'(out_pc),    64'h0);
    check("ar_bubble", 64'(bubble_count), 64'h0);
    drive(1'b1, 32'h13, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_valid",  64'(out_valid), 64'h1);
    check("post_instr",  64'(out_instr), 64'h13);
    check("post_bubble", 64'(bubble_count), 64'h1);

    // Idle long enough to saturate the narrow counter.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (9) tick();
    check("idle_bubble", 64'(bubble_count), 64'h9);
    check("sat_bubble",  64'(s_bubble_count), 64'h7);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
